// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared encodings for the program-counter generator
//
// Purpose: next-PC source selector codes and trap cause codes used by
//          pc_gen and pc_target.
package pc_pkg;

  // Next-PC source selector. Codes 6 and 7 are unused and behave as SEQ.
  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JAL    = 3'd2,
    SEL_JALR   = 3'd3,
    SEL_TRAP   = 3'd4,
    SEL_MRET   = 3'd5
  } pc_sel_e;

  // Cause recorded on trap entry.
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_EXT      = 2'd2
  } cause_e;

endpackage

// File: rtl/pc_target.sv
// rtl/pc_target.sv - control-flow target adder and misalignment detector
//
// Purpose: sign-extends the immediate, forms pc+imm (BRANCH/JAL) or
//          (rs1+imm)&~1 (JALR), and flags targets that are not word aligned.
// Ports:
//   pc_sel_i     in  3       next-PC source selector
//   pc_i         in  ADDR_W  current PC
//   immediate_i  in  IMM_W   signed offset
//   rs1_i        in  ADDR_W  low bits of Reg[rs1]
//   target_o     out ADDR_W  computed target (modulo 2^ADDR_W)
//   misalign_o   out 1       target is not a legal instruction address
module pc_target
  import pc_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int IMM_W  = 21
) (
  input  logic [2:0]        pc_sel_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [IMM_W-1:0]  immediate_i,
  input  logic [ADDR_W-1:0] rs1_i,
  output logic [ADDR_W-1:0] target_o,
  output logic              misalign_o
);

  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] sum;
  logic              is_jalr;

  // Widen with sign bits, or simply truncate when the PC is narrower.
  generate
    if (ADDR_W > IMM_W) begin : g_sext
      assign imm_ext = {{(ADDR_W-IMM_W){immediate_i[IMM_W-1]}}, immediate_i};
    end else begin : g_trunc
      assign imm_ext = immediate_i[ADDR_W-1:0];
    end
  endgenerate

  assign is_jalr = (pc_sel_i == SEL_JALR);
  assign base    = is_jalr ? rs1_i : pc_i;
  assign sum     = base + imm_ext;

  // JALR clears bit0 architecturally, so only bit1 can make it misaligned.
  assign target_o   = is_jalr ? {sum[ADDR_W-1:1], 1'b0} : sum;
  assign misalign_o = is_jalr ? sum[1] : (sum[1] | sum[0]);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - parametrised program-counter generator with trap support
//
// Purpose: selects the next fetch address (SEQ, BRANCH, JAL, JALR, TRAP,
//          MRET), traps on misaligned targets, keeps the saved exception PC,
//          in-trap flag and last cause, and emits registered trap/redirect
//          pulses. Stall freezes all state.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   stall        hold all state, suppress pulses
//   pc_sel       next-PC source selector (see pc_pkg)
//   cond_true    resolved branch condition
//   immediate    signed offset
//   reg_out1     Reg[rs1], low ADDR_W bits used
//   pc_out       current fetch address
//   pc_plus4     pc_out+4 (combinational link value)
//   epc_out      saved exception PC
//   in_trap      trap handler active
//   cause_o      last trap cause
//   trap_o       one-cycle pulse after trap entry
//   redirect_o   one-cycle pulse after any non-sequential load
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter int                IMM_W     = 21,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'('h3F0)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [2:0]        pc_sel,
  input  logic              cond_true,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [31:0]       reg_out1,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc_out,
  output logic              in_trap,
  output logic [1:0]        cause_o,
  output logic              trap_o,
  output logic              redirect_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              in_trap_q, in_trap_d;
  cause_e            cause_q, cause_d;
  logic              trap_q, trap_d;
  logic              redirect_q, redirect_d;

  logic [ADDR_W-1:0] target;
  logic              misalign;
  logic [ADDR_W-1:0] seq_pc;
  logic              unused_rs1_hi;

  assign unused_rs1_hi = ^reg_out1[31:ADDR_W];

  pc_target #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_target (
    .pc_sel_i    (pc_sel),
    .pc_i        (pc_q),
    .immediate_i (immediate),
    .rs1_i       (reg_out1[ADDR_W-1:0]),
    .target_o    (target),
    .misalign_o  (misalign)
  );

  assign seq_pc = pc_q + ADDR_W'(4);

  always_comb begin
    pc_d       = seq_pc;
    epc_d      = epc_q;
    in_trap_d  = in_trap_q;
    cause_d    = cause_q;
    trap_d     = 1'b0;
    redirect_d = 1'b0;

    if (stall) begin
      // Inputs are dropped, not queued; pulses drop for this cycle.
      pc_d = pc_q;
    end else begin
      unique case (pc_sel)
        SEL_BRANCH, SEL_JAL, SEL_JALR: begin
          // An untaken branch falls through to the SEQ defaults.
          if (pc_sel != SEL_BRANCH || cond_true) begin
            redirect_d = 1'b1;
            if (misalign) begin
              pc_d      = TRAP_VEC;
              epc_d     = pc_q;
              in_trap_d = 1'b1;
              cause_d   = CAUSE_MISALIGN;
              trap_d    = 1'b1;
            end else begin
              pc_d = target;
            end
          end
        end
        SEL_TRAP: begin
          // Nested traps simply overwrite epc and cause.
          pc_d       = TRAP_VEC;
          epc_d      = pc_q;
          in_trap_d  = 1'b1;
          cause_d    = CAUSE_EXT;
          trap_d     = 1'b1;
          redirect_d = 1'b1;
        end
        SEL_MRET: begin
          if (in_trap_q) begin
            pc_d       = epc_q;
            in_trap_d  = 1'b0;
            redirect_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      in_trap_q  <= 1'b0;
      cause_q    <= CAUSE_NONE;
      trap_q     <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      in_trap_q  <= in_trap_d;
      cause_q    <= cause_d;
      trap_q     <= trap_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc_out     = pc_q;
  assign pc_plus4   = seq_pc;
  assign epc_out    = epc_q;
  assign in_trap    = in_trap_q;
  assign cause_o    = cause_q;
  assign trap_o     = trap_q;
  assign redirect_o = redirect_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen against a behavioural model
module tb_pc_gen;

  localparam int ADDR_W = 10;
  localparam int IMM_W  = 21;
  localparam int MASK   = (1 << ADDR_W) - 1;
  localparam int TVEC   = 'h3F0;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b0;
  logic [2:0]        pc_sel = 3'd0;
  logic              cond_true = 1'b0;
  logic [IMM_W-1:0]  immediate = '0;
  logic [31:0]       reg_out1 = '0;
  logic [ADDR_W-1:0] pc_out, pc_plus4, epc_out;
  logic              in_trap, trap_o, redirect_o;
  logic [1:0]        cause_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Architectural state of the model, held as plain integers.
  int m_pc, m_epc, m_cause;
  bit m_in_trap, m_trap, m_redir;

  always #5 clk = ~clk;

  pc_gen #(
    .ADDR_W    (ADDR_W),
    .IMM_W     (IMM_W),
    .RESET_VEC ('0),
    .TRAP_VEC  (10'h3F0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc_sel     (pc_sel),
    .cond_true  (cond_true),
    .immediate  (immediate),
    .reg_out1   (reg_out1),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .epc_out    (epc_out),
    .in_trap    (in_trap),
    .cause_o    (cause_o),
    .trap_o     (trap_o),
    .redirect_o (redirect_o)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Next architectural state from the ISA rules for one clock edge.
  task automatic model_step(input bit rst, input bit stl, input int sel,
                            input bit cond, input logic [IMM_W-1:0] imm,
                            input logic [31:0] rs1);
    int  simm, tgt;
    bit  taken, bad;
    simm = int'($signed(imm));
    if (rst) begin
      m_pc = 0; m_epc = 0; m_in_trap = 0; m_cause = 0; m_trap = 0; m_redir = 0;
      return;
    end
    m_trap = 0; m_redir = 0;
    if (stl) return;
    taken = 0; bad = 0; tgt = 0;
    if (sel == 1 || sel == 2) begin
      taken = (sel == 2) || cond;
      tgt   = (m_pc + simm) & MASK;
      bad   = (tgt % 4) != 0;
    end else if (sel == 3) begin
      taken = 1;
      tgt   = ((int'(rs1) & MASK) + simm) & MASK & ~1;
      bad   = (tgt % 4) != 0;
    end
    if (sel == 4 || (taken && bad)) begin
      m_epc = m_pc; m_pc = TVEC; m_in_trap = 1;
      m_cause = (sel == 4) ? 2 : 1;
      m_trap = 1; m_redir = 1;
    end else if (taken) begin
      m_pc = tgt; m_redir = 1;
    end else if (sel == 5 && m_in_trap) begin
      m_pc = m_epc; m_in_trap = 0; m_redir = 1;
    end else begin
      m_pc = (m_pc + 4) & MASK;
    end
  endtask

  // Drive one cycle; inputs change 1 time unit after the active edge.
  task automatic step(input bit rst, input bit stl, input int sel, input bit cond,
                      input int imm, input int rs1);
    reset = rst; stall = stl; pc_sel = 3'(sel); cond_true = cond;
    immediate = IMM_W'(imm); reg_out1 = 32'(rs1);
    @(posedge clk);
    model_step(rst, stl, sel, cond, IMM_W'(imm), 32'(rs1));
    chk_en = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc_out",     int'(pc_out),     m_pc);
      chk("pc_plus4",   int'(pc_plus4),   (m_pc + 4) & MASK);
      chk("epc_out",    int'(epc_out),    m_epc);
      chk("in_trap",    int'(in_trap),    int'(m_in_trap));
      chk("cause_o",    int'(cause_o),    m_cause);
      chk("trap_o",     int'(trap_o),     int'(m_trap));
      chk("redirect_o", int'(redirect_o), int'(m_redir));
    end
  end

  initial begin
    // Reset then three sequential fetches.
    step(1, 0, 0, 0, 0, 0);
    chk("rst_pc", int'(pc_out), 0);
    chk("rst_epc", int'(epc_out), 0);
    chk("rst_flags", int'({in_trap, cause_o, trap_o, redirect_o}), 0);
    step(0, 0, 0, 0, 0, 0); chk("seq_4", int'(pc_out), 4);
    step(0, 0, 0, 0, 0, 0); chk("seq_8", int'(pc_out), 8);
    step(0, 0, 0, 0, 0, 0); chk("seq_12", int'(pc_out), 12);
    chk("seq_no_redir", int'(redirect_o), 0);

    // Taken branch back to 0 from pc=8, then pulse drops.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, -8, 0);
    chk("br_taken_pc", int'(pc_out), 0);
    chk("br_taken_redir", int'(redirect_o), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("br_redir_drop", int'(redirect_o), 0);

    // Untaken branch at pc=8.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, -8, 0);
    chk("br_untaken_pc", int'(pc_out), 12);
    chk("br_untaken_redir", int'(redirect_o), 0);

    // JAL to 16, JALR to 0x104, then misaligned JAL traps.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 2, 0, 16, 0);
    chk("jal_16", int'(pc_out), 16);
    step(0, 0, 3, 0, 3, 'h101);
    chk("jalr_pc", int'(pc_out), 'h104);
    step(0, 0, 2, 0, 2, 0);
    chk("mis_pc", int'(pc_out), 'h3F0);
    chk("mis_epc", int'(epc_out), 'h104);
    chk("mis_cause", int'(cause_o), 1);
    chk("mis_trap", int'(trap_o), 1);
    chk("mis_in_trap", int'(in_trap), 1);
    step(0, 0, 5, 0, 0, 0);
    chk("mret_pc", int'(pc_out), 'h104);
    chk("mret_in_trap", int'(in_trap), 0);
    chk("mret_redir", int'(redirect_o), 1);
    step(0, 0, 5, 0, 0, 0);
    chk("mret2_pc", int'(pc_out), 'h108);
    chk("mret2_redir", int'(redirect_o), 0);

    // Wrap-around at the top of the address space.
    step(0, 0, 3, 0, 0, 'h3FC);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_seq", int'(pc_out), 0);
    step(0, 0, 3, 0, 0, 'h3F8);
    step(0, 0, 2, 0, 12, 0);
    chk("wrap_jal", int'(pc_out), 4);

    // Stall holds everything and ignores TRAP; reset overrides stall.
    step(0, 0, 4, 0, 0, 0);
    step(0, 0, 2, 0, 8, 0);
    step(0, 1, 4, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0);
    chk("stall_pc", int'(pc_out), 'h3F8);
    chk("stall_epc", int'(epc_out), 'h3F0 - 'h3F0 + 4);
    chk("stall_pulses", int'({trap_o, redirect_o}), 0);
    step(1, 1, 4, 0, 0, 0);
    chk("rst_in_stall", int'(pc_out), 0);

    // Randomized traffic checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      int r_imm;
      r_imm = int'($urandom_range(0, 'h7FF)) - 'h400;
      if ($urandom_range(0, 3) != 0) r_imm = r_imm & ~3;
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 7)), 1'($urandom), r_imm, int'($urandom));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
